// File: rtl/i2c_slave_regs_if.sv
// Split T/I/O pad bundle for SCL and SDA as seen from the target side of an I2C hub.
// The slave modport reads the pad levels and drives the open-drain controls.
interface i2c_slave_regs_if;
  logic scl_I;
  logic scl_O;
  logic scl_T;
  logic sda_I;
  logic sda_O;
  logic sda_T;

  modport slave  (input scl_I, sda_I, output scl_O, scl_T, sda_O, sda_T);
  modport master (output scl_I, sda_I, input scl_O, scl_T, sda_O, sda_T);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a byte register file, pointer auto-increment and open-drain SDA only.
// Acts ~6 clk after a pad edge (2-FF sync + FILT_LEN filter + edge detect); never stretches SCL.
module i2c_slave_regs #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  parameter int         PTR_W    = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_slave_regs_if.slave       bus,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic                  busy
);

  localparam int FC_W = $clog2(FILT_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]      raw;
  logic [1:0]      s1_q, s2_q, f_q, fd_q;
  logic [FC_W-1:0] fcnt_q [2];

  state_t          state_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      sh_q;
  logic            rw_q;
  logic            first_q;
  logic [PTR_W-1:0] ptr_q;
  logic            sda_t_q;
  logic            busy_q;
  logic            wr_stb_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [7:0]      regs_q [NUM_REGS];

  logic            scl_rise, scl_fall, start_c, stop_c, sda_bit, wr_fire;
  logic [7:0]      byte_in;
  logic [7:0]      reg_at_ptr;

  assign raw = {bus.sda_I, bus.scl_I};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      f_q       <= '1;
      fd_q      <= '1;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      fd_q <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
          f_q[i]    <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FC_W'(1);
        end
      end
    end
  end

  assign scl_rise   = f_q[0] & ~fd_q[0];
  assign scl_fall   = ~f_q[0] & fd_q[0];
  assign start_c    = f_q[0] & fd_q[0] & ~f_q[1] & fd_q[1];
  assign stop_c     = f_q[0] & fd_q[0] & f_q[1] & ~fd_q[1];
  assign sda_bit    = f_q[1];
  assign byte_in    = {sh_q[6:0], sda_bit};
  assign reg_at_ptr = regs_q[ptr_q];

  // A completed data byte lands in the register file regardless of a coincident STOP.
  assign wr_fire = (state_q == S_WR_BYTE) && scl_rise && (bit_cnt_q == 4'd7) && !first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else if (wr_fire) begin
      regs_q[ptr_q] <= byte_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      first_q   <= 1'b1;
      ptr_q     <= '0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_ptr_q  <= '0;
    end else begin
      wr_stb_q <= wr_fire;
      if (wr_fire) begin
        wr_ptr_q <= ptr_q;
        ptr_q    <= ptr_q + PTR_W'(1);
      end

      if (stop_c) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        sda_t_q   <= 1'b1;
        busy_q    <= 1'b0;
      end else if (start_c) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        sda_t_q   <= 1'b1;
        first_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              sh_q      <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (byte_in[7:1] == SLV_ADDR) begin
                  busy_q  <= 1'b1;
                  rw_q    <= byte_in[0];
                  state_q <= S_ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
                end
              end
            end
          end
          // bit_cnt_q doubles as the "ACK already driven" flag in the ACK states.
          S_ADDR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd0) begin
                sda_t_q   <= 1'b0;
                bit_cnt_q <= 4'd1;
              end else begin
                bit_cnt_q <= '0;
                if (state_q == S_WR_ACK || !rw_q) begin
                  sda_t_q <= 1'b1;
                  state_q <= S_WR_BYTE;
                end else begin
                  sh_q    <= reg_at_ptr;
                  sda_t_q <= reg_at_ptr[7];
                  state_q <= S_RD_BYTE;
                end
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise) begin
              sh_q      <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                state_q   <= S_WR_ACK;
                if (first_q) begin
                  ptr_q   <= byte_in[PTR_W-1:0];
                  first_q <= 1'b0;
                end
              end
            end
          end
          S_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) ptr_q <= ptr_q + PTR_W'(1);
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_t_q   <= 1'b1;
                bit_cnt_q <= '0;
                state_q   <= S_RD_ACK;
              end else begin
                sda_t_q <= sh_q[~bit_cnt_q[2:0]];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_bit) bit_cnt_q <= 4'd1;
              else          state_q   <= S_IDLE;
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              bit_cnt_q <= '0;
              sh_q      <= reg_at_ptr;
              sda_t_q   <= reg_at_ptr[7];
              state_q   <= S_RD_BYTE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs_q[k];
  end

  assign bus.scl_O = 1'b0;
  assign bus.scl_T = 1'b1;
  assign bus.sda_O = 1'b0;
  assign bus.sda_T = sda_t_q;
  assign wr_stb    = wr_stb_q;
  assign wr_ptr    = wr_ptr_q;
  assign busy      = busy_q;

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C responder (target) with an internal byte-wide register file, attached to the downstream side of the I2C hub using the split T/I/O pad convention.
- Decodes START, STOP and repeated START, and matches a 7-bit address.
- Accepts a register pointer followed by write data, and returns register contents on reads with pointer auto-increment.
- Open-drain only: never drives high and never stretches SCL.

Parameters:
- SLV_ADDR, 7'h50: 7-bit target address matched against the address byte.
- NUM_REGS, 16: register count, power of two, 2..256; the pointer wraps modulo NUM_REGS.
- PTR_W, 4: pointer width, equal to log2(NUM_REGS).
- FILT_LEN, 3: consecutive equal synchronized samples needed to accept a new SCL/SDA level (glitch filter).

Ports:
- clk input 1: system clock, at least 20x the SCL frequency.
- rst input 1: asynchronous, active-high reset.
- scl_I input 1: SCL pad level as read.
- scl_O output 1: SCL drive value, constant 0.
- scl_T output 1: SCL tristate, constant 1 (released).
- sda_I input 1: SDA pad level as read.
- sda_O output 1: SDA drive value, constant 0.
- sda_T output 1: SDA tristate; 0 pulls SDA low, 1 releases it.
- regs_flat output 8*NUM_REGS: register file, with register k at bits [8k+7:8k].
- wr_stb output 1: one-cycle pulse when a data byte is written.
- wr_ptr output PTR_W: register index written; valid with wr_stb.
- busy output 1: high from an address match until STOP, or until a START with an address mismatch.

Behaviour:
- Reset values: sda_T=1, all regs 0, pointer 0, wr_stb=0, wr_ptr=0, busy=0, state IDLE. Reset mid-transaction releases SDA in the same cycle (asynchronous).
- Input conditioning:
  - 2-FF synchronizer per line, then the FILT_LEN filter.
  - Edge and condition detection works on the filtered levels, one clk after a filtered change.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data bits are sampled on the filtered SCL rise; SDA is updated on the filtered SCL fall.
- START or repeated START, from any state: bit counter cleared, state ADDR. The pointer is kept.
- STOP, from any state: state IDLE, sda_T=1, busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
    - Upper 7 bits equal SLV_ADDR: busy=1, then ADDR_ACK.
    - Otherwise: IDLE, with SDA never driven.
  - ADDR_ACK:
    - On the SCL fall after bit 8: sda_T=0.
    - On the next SCL fall: sda_T=1 for a write (R/W=0), then WR_BYTE.
    - For a read (R/W=1), go to RD_BYTE and present reg[ptr] bit 7 on the same fall.
  - WR_BYTE: shift 8 bits, then WR_ACK.
    - The first byte after the address is loaded into the pointer (modulo NUM_REGS).
    - Later bytes write reg[ptr] on the 8th SCL rise, with wr_stb=1 and wr_ptr=ptr for one clk. The pointer then increments and wraps.
  - WR_ACK: always ACK (sda_T=0 for the 9th clock), then WR_BYTE.
  - RD_BYTE:
    - Drive sda_T = data bit (bit 1 releases, bit 0 pulls low), MSB first, updated on each SCL fall.
    - The read byte is latched when bit 7 is presented.
    - The pointer increments after the 8th bit; then RD_ACK with sda_T=1.
  - RD_ACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): RD_BYTE, next byte presented on the following fall.
    - 1 (NACK): IDLE, SDA released, busy remains until STOP.
- "First byte" is tracked per transaction: a repeated START into a write resets it, so the first byte is again the pointer.
- A write register update and a STOP detected in the same clk: the register update completes.
- A truncated byte (STOP or START before 8 bits): no register write and no pointer change.
- SDA is never driven while SCL is high except when holding an ACK or data bit across that high phase.

Test Plan:
- Write 0x50<<1|0, 0x03, 0xA5, 0x5A, STOP → ACK on all 4 bytes; reg3=0xA5 and reg4=0x5A; two wr_stb pulses with wr_ptr 3 then 4; busy falls at STOP.
- Then write 0xA0, 0x03, repeated START, 0xA1; master ACKs the 1st read byte and NACKs the 2nd → read bytes 0xA5, 0x5A; SDA released after the NACK; pointer=5.
- Address 0x51 with a write of 0x10 → SDA never low (sda_T stays 1), busy=0, no register changes.
- Pointer 0x0F, write 0x11, 0x22 → reg15=0x11 and reg0=0x22 (wrap).
- STOP after 4 data bits of a write byte → no wr_stb, register unchanged; a following transaction is ACKed normally.
- Assert rst during RD_BYTE while a 0 bit is being driven → sda_T=1 immediately; regs cleared; the next valid transaction succeeds.
